// File: rtl/cpu1_control_unit_if.sv
// CPU1 control-unit bus: memory port, accumulator write controls and status.
// Memory: mem_rd/mem_wr and mem_addr stay steady until the cycle mem_ready is 1, which completes the access.
interface cpu1_control_unit_if;
   logic       start;
   logic [3:0] mem_addr;
   logic       mem_rd;
   logic       mem_wr;
   logic [7:0] mem_rdata;
   logic       mem_ready;
   logic       acc_zero;
   logic       acc_en;
   logic       acc_clr;
   logic [2:0] alu_op;
   logic [3:0] pc;
   logic       halted;
   logic       illegal;
   logic [2:0] state_dbg;

   modport master (
      input  start, mem_rdata, mem_ready, acc_zero,
      output mem_addr, mem_rd, mem_wr, acc_en, acc_clr, alu_op, pc, halted, illegal, state_dbg
   );

   modport slave (
      output start, mem_rdata, mem_ready, acc_zero,
      input  mem_addr, mem_rd, mem_wr, acc_en, acc_clr, alu_op, pc, halted, illegal, state_dbg
   );
endinterface

// File: rtl/cpu1_control_unit.sv
// CPU1 instruction sequencer: PC/IR, fetch-decode-execute FSM, accumulator and memory strobes.
// Optional macro CPU1_CTRL_ILLEGAL_TRAP_EN: opcodes A-E set a sticky illegal flag and halt.
module cpu1_control_unit #(
   parameter logic [3:0] RESET_PC   = 4'h0,
   parameter bit         AUTO_START = 1'b0
) (
   input logic                 clk,
   input logic                 rst,
   cpu1_control_unit_if.master bus
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_HALT   = 3'd4
   } state_t;

   localparam logic [3:0] OP_LDA = 4'h1;
   localparam logic [3:0] OP_ADD = 4'h2;
   localparam logic [3:0] OP_SUB = 4'h3;
   localparam logic [3:0] OP_AND = 4'h4;
   localparam logic [3:0] OP_OR  = 4'h5;
   localparam logic [3:0] OP_STA = 4'h6;
   localparam logic [3:0] OP_JMP = 4'h7;
   localparam logic [3:0] OP_JZ  = 4'h8;
   localparam logic [3:0] OP_CLR = 4'h9;
   localparam logic [3:0] OP_HLT = 4'hF;

   state_t     r_state;
   logic [3:0] r_pc;
   logic [7:0] r_ir;

   logic [3:0] w_op;
   logic [3:0] w_opnd;
   logic       w_alu_class;
   logic       w_mem_class;
   logic [2:0] w_alu_sel;

   assign w_op        = r_ir[7:4];
   assign w_opnd      = r_ir[3:0];
   assign w_alu_class = (w_op >= OP_LDA) && (w_op <= OP_OR);
   assign w_mem_class = w_alu_class || (w_op == OP_STA);

`ifdef CPU1_CTRL_ILLEGAL_TRAP_EN
   logic r_illegal;
   logic w_undef;
   assign w_undef     = (w_op >= 4'hA) && (w_op <= 4'hE);
   assign bus.illegal = r_illegal;
`else
   assign bus.illegal = 1'b0;
`endif

   always_comb begin
      w_alu_sel = 3'd0;
      case (w_op)
         OP_ADD:  w_alu_sel = 3'd1;
         OP_SUB:  w_alu_sel = 3'd2;
         OP_AND:  w_alu_sel = 3'd3;
         OP_OR:   w_alu_sel = 3'd4;
         default: w_alu_sel = 3'd0;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_pc      <= RESET_PC;
         r_ir      <= 8'h00;
`ifdef CPU1_CTRL_ILLEGAL_TRAP_EN
         r_illegal <= 1'b0;
`endif
      end else begin
         case (r_state)
            S_IDLE: begin
               if (bus.start || AUTO_START) r_state <= S_FETCH;
            end
            S_FETCH: begin
               if (bus.mem_ready) begin
                  r_ir    <= bus.mem_rdata;
                  r_pc    <= r_pc + 4'd1;
                  r_state <= S_DECODE;
               end
            end
            S_DECODE: begin
               r_state <= S_FETCH;
               if ((w_op == OP_JMP) || ((w_op == OP_JZ) && bus.acc_zero)) r_pc <= w_opnd;
               if (w_op == OP_HLT) begin
                  r_state <= S_HALT;
               end else if (w_mem_class) begin
                  r_state <= S_EXEC;
               end
`ifdef CPU1_CTRL_ILLEGAL_TRAP_EN
               else if (w_undef) begin
                  r_illegal <= 1'b1;
                  r_state   <= S_HALT;
               end
`endif
            end
            S_EXEC: begin
               if (bus.mem_ready) r_state <= S_FETCH;
            end
            S_HALT:  r_state <= S_HALT;
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // Strobes decode straight from state so an async reset drops them in the same cycle.
   always_comb begin
      bus.mem_addr = r_pc;
      bus.mem_rd   = 1'b0;
      bus.mem_wr   = 1'b0;
      bus.acc_en   = 1'b0;
      bus.acc_clr  = 1'b0;
      bus.alu_op   = 3'd0;
      case (r_state)
         S_FETCH: bus.mem_rd = 1'b1;
         S_DECODE: begin
            bus.acc_clr = (w_op == OP_CLR);
            bus.alu_op  = w_alu_sel;
         end
         S_EXEC: begin
            bus.mem_addr = w_opnd;
            bus.mem_rd   = w_alu_class;
            bus.mem_wr   = (w_op == OP_STA);
            bus.acc_en   = w_alu_class && bus.mem_ready;
            bus.alu_op   = w_alu_sel;
         end
         default: ;
      endcase
   end

   assign bus.pc        = r_pc;
   assign bus.halted    = (r_state == S_HALT);
   assign bus.state_dbg = r_state;

endmodule
